// File: rtl/sub16_pkg.sv
// rtl/sub16_pkg.sv - shared widths and types for the pipelined subtractor
package sub16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int HALF      = WIDTH_DEF / 2;

    typedef logic [HALF-1:0]      half_t;
    typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/sub_half.sv
// rtl/sub_half.sv - combinational half-width subtract with borrow in and borrow out
module sub_half
    import sub16_pkg::*;
#(
    parameter int W = HALF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] full;

    // One extra bit catches the borrow: any negative result sets bit W.
    assign full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
    assign d    = full[W-1:0];
    assign bout = full[W];

endmodule

// File: rtl/sub16_pipe.sv
// rtl/sub16_pipe.sv - two-stage valid/ready subtractor, signed overflow flag under SUB16_OVF_EN
module sub16_pipe
    import sub16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             borrow,
    output logic             ovf
);

    localparam int H = WIDTH / 2;

    logic         s1_valid_q, s1_valid_d;
    logic         s2_valid_q, s2_valid_d;
    logic [H-1:0] lo_q, lo_d;
    logic         bl_q, bl_d;
    logic [H-1:0] a_hi_q, b_hi_q;
    logic [H-1:0] hi_d;
    logic         bh_d;
    logic [WIDTH-1:0] o_q;
    logic         borrow_q;
    logic         accept;
    logic         s2_adv;

    sub_half #(.W(H)) u_lo (
        .x    (a[H-1:0]),
        .y    (b[H-1:0]),
        .bin  (1'b0),
        .d    (lo_d),
        .bout (bl_d)
    );

    sub_half #(.W(H)) u_hi (
        .x    (a_hi_q),
        .y    (b_hi_q),
        .bin  (bl_q),
        .d    (hi_d),
        .bout (bh_d)
    );

    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign accept   = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            lo_q       <= '0;
            bl_q       <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            o_q        <= '0;
            borrow_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                lo_q   <= lo_d;
                bl_q   <= bl_d;
                a_hi_q <= a[WIDTH-1:H];
                b_hi_q <= b[WIDTH-1:H];
            end
            if (s2_adv) begin
                o_q      <= {hi_d, lo_q};
                borrow_q <= bh_d;
            end
        end
    end

`ifdef SUB16_OVF_EN
    logic ovf_q, ovf_d;

    // The operand sign bits are already held as the MSBs of the high halves.
    assign ovf_d = (a_hi_q[H-1] != b_hi_q[H-1]) & (hi_d[H-1] != a_hi_q[H-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (s2_adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = s2_valid_q;
    assign o         = o_q;
    assign borrow    = borrow_q;

endmodule
